// File: rtl/quad_updown_decoder.sv
// Quadrature phase receiver: synchronizes encoder phases a/b, decodes 4x Gray-code
// edges into up/down steps on a wrapping position, and flags illegal double edges.
module quad_updown_decoder #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             a,
  input  logic             b,
  input  logic             clear,
  input  logic             err_clr,
  output logic [WIDTH-1:0] y,
  output logic             dir,
  output logic             step,
  output logic             err
);

  // state | meaning
  // PRIME | load prev from the synchronized pins for SYNC_STAGES+1 edges; no decode
  // RUN   | decode every edge of prev -> s into up/down steps or an illegal flag
  typedef enum logic {PRIME, RUN} state_t;

  localparam int CW = $clog2(SYNC_STAGES + 1) + 1;

  state_t                 state;
  logic [CW-1:0]          prime_cnt;
  logic [SYNC_STAGES-1:0] a_sync;
  logic [SYNC_STAGES-1:0] b_sync;
  logic [1:0]             prev;
  logic [1:0]             s;
  logic                   fwd;
  logic                   bwd;
  logic                   illegal;

  // Up sequence is 00 -> 10 -> 11 -> 01 -> 00 (A leads B).
  function automatic logic [1:0] up_next(input logic [1:0] p);
    case (p)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] dn_next(input logic [1:0] p);
    case (p)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  assign s       = {a_sync[SYNC_STAGES-1], b_sync[SYNC_STAGES-1]};
  assign fwd     = (s == up_next(prev));
  assign bwd     = (s == dn_next(prev));
  assign illegal = ((s ^ prev) == 2'b11);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= PRIME;
      prime_cnt <= CW'(SYNC_STAGES);
      a_sync    <= '0;
      b_sync    <= '0;
      prev      <= 2'b00;
      y         <= '0;
      dir       <= 1'b0;
      step      <= 1'b0;
      err       <= 1'b0;
    end else begin
      a_sync <= {a_sync[SYNC_STAGES-2:0], a};
      b_sync <= {b_sync[SYNC_STAGES-2:0], b};
      prev   <= s;
      step   <= 1'b0;
      if (clear) y <= '0;
      case (state)
        PRIME: begin
          if (prime_cnt == '0) state <= RUN;
          else                 prime_cnt <= prime_cnt - CW'(1);
          if (err_clr) err <= 1'b0;
        end
        RUN: begin
          // A coincident illegal edge wins over err_clr.
          if (illegal)      err <= 1'b1;
          else if (err_clr) err <= 1'b0;
          if (!clear) begin
            if (fwd) begin
              y    <= y + WIDTH'(1);
              dir  <= 1'b1;
              step <= 1'b1;
            end else if (bwd) begin
              y    <= y - WIDTH'(1);
              dir  <= 1'b0;
              step <= 1'b1;
            end
          end
        end
        default: state <= PRIME;
      endcase
    end
  end

endmodule

// File: tb/tb_quad_updown_decoder.sv
// Directed bench for quad_updown_decoder: scoreboard of expected outputs pushed per
// pin change, popped at the decode edge, plus step-pulse counting and reset/prime checks.
module tb_quad_updown_decoder;

  logic       clock = 1'b0;
  logic       reset;
  logic       a, b, clear, err_clr;
  logic [3:0] y;
  logic       dir, step, err;

  int tests = 0;
  int fails = 0;
  int step_seen = 0;
  logic [3:0] cur_y;

  typedef struct {
    string      tag;
    logic [3:0] y;
    logic       dir;
    logic       step;
    logic       err;
  } exp_t;
  exp_t sb[$];

  quad_updown_decoder #(.WIDTH(4), .SYNC_STAGES(2)) dut (
    .clock(clock), .reset(reset), .a(a), .b(b), .clear(clear), .err_clr(err_clr),
    .y(y), .dir(dir), .step(step), .err(err)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    #2;
    if (step === 1'b1) step_seen++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive a pin pair at a falling edge; the outputs must stay put through E1 and
  // show the decoded result right after E2. Optional clear/err_clr only at E2.
  task automatic move(input string tag, input logic [1:0] ab, input logic c, input logic ec,
                      input logic [3:0] ey, input logic edir, input logic estep,
                      input logic eerr);
    exp_t e;
    {a, b} = ab;
    sb.push_back('{tag, ey, edir, estep, eerr});
    @(negedge clock);
    @(negedge clock);
    chk({tag, "_early_y"}, y, cur_y);
    chk({tag, "_early_step"}, step, 0);
    clear   = c;
    err_clr = ec;
    @(negedge clock);
    clear   = 1'b0;
    err_clr = 1'b0;
    e = sb.pop_front();
    chk({e.tag, "_y"}, y, e.y);
    chk({e.tag, "_dir"}, dir, e.dir);
    chk({e.tag, "_step"}, step, e.step);
    chk({e.tag, "_err"}, err, e.err);
    cur_y = e.y;
    repeat (3) @(negedge clock);
  endtask

  initial begin
    int s0;
    reset = 1'b1; a = 1'b0; b = 1'b0; clear = 1'b0; err_clr = 1'b0;
    cur_y = 4'd0;
    repeat (3) @(negedge clock);
    chk("rst_y", y, 0);
    chk("rst_dir", dir, 0);
    chk("rst_step", step, 0);
    chk("rst_err", err, 0);
    reset = 1'b0;
    repeat (4) @(negedge clock);

    // up count
    s0 = step_seen;
    move("up1", 2'b10, 0, 0, 4'd1, 1, 1, 0);
    move("up2", 2'b11, 0, 0, 4'd2, 1, 1, 0);
    move("up3", 2'b01, 0, 0, 4'd3, 1, 1, 0);
    move("up4", 2'b00, 0, 0, 4'd4, 1, 1, 0);
    chk("up_pulses", step_seen - s0, 4);

    // down and wrap
    move("dn1", 2'b01, 0, 0, 4'd3, 0, 1, 0);
    move("dn2", 2'b11, 0, 0, 4'd2, 0, 1, 0);
    move("dn3", 2'b10, 0, 0, 4'd1, 0, 1, 0);
    move("dn4", 2'b00, 0, 0, 4'd0, 0, 1, 0);
    move("dn_wrap", 2'b01, 0, 0, 4'd15, 0, 1, 0);
    move("up_wrap", 2'b00, 0, 0, 4'd0, 1, 1, 0);

    // reach y=5 at 00 via a standalone clear at phase 01
    move("b1", 2'b10, 0, 0, 4'd1, 1, 1, 0);
    move("b2", 2'b11, 0, 0, 4'd2, 1, 1, 0);
    move("b3", 2'b01, 0, 0, 4'd3, 1, 1, 0);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    chk("clear_y", y, 0);
    cur_y = 4'd0;
    repeat (2) @(negedge clock);
    move("b4", 2'b00, 0, 0, 4'd1, 1, 1, 0);
    move("b5", 2'b10, 0, 0, 4'd2, 1, 1, 0);
    move("b6", 2'b11, 0, 0, 4'd3, 1, 1, 0);
    move("b7", 2'b01, 0, 0, 4'd4, 1, 1, 0);
    move("b8", 2'b00, 0, 0, 4'd5, 1, 1, 0);

    // illegal transitions and error clearing
    s0 = step_seen;
    move("ill1", 2'b11, 0, 0, 4'd5, 1, 0, 1);
    chk("ill1_no_step", step_seen - s0, 0);
    err_clr = 1'b1;
    @(negedge clock);
    err_clr = 1'b0;
    chk("errclr", err, 0);
    move("ill2_set_wins", 2'b00, 0, 1, 4'd5, 1, 0, 1);

    // clear priority over a coincident up step
    move("c1", 2'b10, 0, 0, 4'd6, 1, 1, 1);
    move("c2", 2'b11, 0, 0, 4'd7, 1, 1, 1);
    move("clr_prio", 2'b01, 1, 0, 4'd0, 1, 0, 1);
    move("after_clr", 2'b00, 0, 0, 4'd1, 1, 1, 1);

    // climb to 9, then an illegal jump to 11 keeps err set
    move("r1", 2'b10, 0, 0, 4'd2, 1, 1, 1);
    move("r2", 2'b11, 0, 0, 4'd3, 1, 1, 1);
    move("r3", 2'b01, 0, 0, 4'd4, 1, 1, 1);
    move("r4", 2'b00, 0, 0, 4'd5, 1, 1, 1);
    move("r5", 2'b10, 0, 0, 4'd6, 1, 1, 1);
    move("r6", 2'b11, 0, 0, 4'd7, 1, 1, 1);
    move("r7", 2'b01, 0, 0, 4'd8, 1, 1, 1);
    move("r8", 2'b00, 0, 0, 4'd9, 1, 1, 1);
    move("r_ill", 2'b11, 0, 0, 4'd9, 1, 0, 1);

    // asynchronous reset between edges, then prime with pins resting at 11
    @(posedge clock);
    #3 reset = 1'b1;
    #1;
    chk("async_rst_y", y, 0);
    chk("async_rst_err", err, 0);
    chk("async_rst_dir", dir, 0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    cur_y = 4'd0;
    s0 = step_seen;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      chk($sformatf("prime_err_%0d", i), err, 0);
    end
    chk("prime_no_step", step_seen - s0, 0);
    move("post_prime", 2'b01, 0, 0, 4'd1, 1, 1, 0);

    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/quad_updown_decoder.md
# quad_updown_decoder

Quadrature receiver that turns two asynchronous encoder phase inputs into the direction and count signals an up/down position counter needs. It synchronizes phases `a` and `b`, decodes every legal Gray-code edge (4x decoding) into an up or down step, and keeps a wrapping `WIDTH`-bit position. It sits between the external encoder pins and the up/down counting logic, and flags illegal double-edge transitions.

## Interface
- `WIDTH`, default 4: position width; wraps modulo 2^WIDTH.
- `SYNC_STAGES`, default 2, minimum 2: synchronizer flops per phase input.

- `clock`  in  1  single clock; every register updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `a`  in  1  encoder phase A; asynchronous to `clock`.
- `b`  in  1  encoder phase B; asynchronous to `clock`.
- `clear`  in  1  synchronous: zero the position.
- `err_clr`  in  1  synchronous: clear the sticky error flag.
- `y`  out  WIDTH  current position.
- `dir`  out  1  direction of the last counted step: 1 = up, 0 = down.
- `step`  out  1  one-cycle pulse on each counted step.
- `err`  out  1  sticky illegal-transition flag.

## Operation
- Synchronizers:
  - Each phase passes through a `SYNC_STAGES`-deep flop chain.
  - The synchronized pair is `s = {a_s, b_s}`; register `prev` holds the last decoded `s`.
- FSM, two states:
  - PRIME:
    - Entered on reset.
    - Stays for `SYNC_STAGES`+1 rising edges after `reset` falls.
    - Each edge loads `prev` <= `s`; no counting and no error detection.
    - Prevents spurious steps when the encoder rests at a non-00 state at reset release.
  - RUN: decodes every edge. Never leaves RUN except through `reset`.
- Decode in RUN, comparing `prev` to `s`:
  - Up sequence is 00→10→11→01→00 (A leads B).
  - `s` equals `prev`: no action.
  - One-step forward in the up sequence: `y` <= `y`+1, `dir` <= 1, `step` <= 1.
  - One-step backward: `y` <= `y`−1, `dir` <= 0, `step` <= 1.
  - Both bits change (00↔11, 10↔01): illegal.
    - `err` <= 1.
    - `y`, `dir` unchanged; `step` <= 0.
  - `prev` <= `s` every RUN edge, including illegal edges.
- Arithmetic: unsigned and modulo 2^WIDTH. 2^WIDTH−1 +1 → 0; 0 −1 → 2^WIDTH−1. No saturation.
- `clear` priority:
  - Forces `y` <= 0 and overrides a coincident step: `step` stays 0 and `dir` is unchanged.
  - `prev` still tracks `s`.
  - An illegal transition in the same cycle still sets `err`.
  - `clear` is honoured in PRIME as well.
- `err_clr`:
  - Clears `err` when no illegal transition occurs that cycle.
  - If an illegal transition coincides with it, set wins and `err` stays 1.
- `step` is high for exactly one cycle per counted transition. A new transition on the next cycle produces another single-cycle pulse.

## Timing
- Reset values, applied asynchronously as soon as `reset` rises with no clock edge needed:
  - `y` = 0, `dir` = 0, `step` = 0, `err` = 0.
  - Synchronizers and `prev` = 00.
  - FSM = PRIME.
- Reset asserted mid-operation discards any in-flight transition. After release, the FSM re-primes on the current pin state.
- Latency:
  - Rising edge E0 is the first edge to capture a changed phase.
  - The change reaches `s` at edge E(SYNC_STAGES−1).
  - `y`, `dir`, `step` and `err` update at edge E(SYNC_STAGES), i.e. 3 edges counting E0 when `SYNC_STAGES`=2.
- Input rate: phase changes must be separated by ≥ `SYNC_STAGES`+1 clocks.
  - Faster changes can merge into an illegal double-edge, which is flagged through `err` and not counted.
- `clear` and `err_clr` take effect at the next rising edge (1 cycle). Neither requires a handshake.

## Test plan
Defaults: `WIDTH`=4, `SYNC_STAGES`=2.
- Up count: reset with a=b=0, wait 4 clocks, then drive {a,b} 10, 11, 01, 00, each held 6 clocks.
  - Required: `y` = 1, 2, 3, 4; `dir` = 1; exactly 4 single-cycle `step` pulses.
  - Each update lands 3 edges after the pin change.
- Down and wrap: from `y`=4 at {a,b}=00, drive 01, 11, 10, 00, 01.
  - Required: `y` = 3, 2, 1, 0, 15; `dir` = 0.
  - One further up transition (01→00) gives `y` = 0 and `dir` = 1.
- Illegal transition and error clearing:
  - At {a,b}=00 with `y`=5, jump to 11. Required: `err` = 1, `y` = 5, `step` never high.
  - Pulse `err_clr`. Required: `err` = 0.
  - Jump 11→00 with `err_clr` held high that same decode cycle. Required: `err` stays 1.
- Clear priority: with `y`=7, assert `clear` in the exact cycle an up step decodes.
  - Required: `y` = 0, `step` = 0.
  - The next legal up step gives `y` = 1.
- Asynchronous reset and prime:
  - With `y`=9 and `err`=1, raise `reset` between clock edges. Required: `y` = 0 and `err` = 0 before the next edge.
  - Hold a=b=1 through release. Required: no `step` and no `err` during PRIME.
  - Then drive 01. Required: `y` = 1, `dir` = 1.
